// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: turns one memory-stage load/store into a valid/ready data-bus
// transaction, stalls the pipeline until it completes, and returns lane-aligned,
// extended load data. Flags illegal/misaligned requests and bus timeouts.
module dmem_bus_bridge #(
    parameter int unsigned TIMEOUT = 255    // cycles allowed in REQ+WAIT_R, must be >= 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd_en,
    input  logic        req_wr_en,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_length,
    input  logic        req_sign,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        WAIT_R = 2'b10,
        DONE   = 2'b11
    } state_t;

    // Bus request payload, held stable for the whole transaction.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } bus_req_t;

    state_t            state_q, state_d;
    bus_req_t          breq_q, breq_d;
    logic              bus_valid_q, bus_valid_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        len_q, len_d;
    logic              sign_q, sign_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              err_q, err_d;

    logic              req_any_c;
    logic              illegal_c;
    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] shifted_c;
    logic [DATA_W-1:0] load_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              timeout_c;

    // Request decode: legality check, byte enables and lane-replicated store data.
    always_comb begin
        req_any_c = req_rd_en | req_wr_en;
        illegal_c = (req_rd_en & req_wr_en)
                  | (req_length == 2'b11)
                  | ((req_length == LEN_HALF) & req_addr[0])
                  | ((req_length == LEN_WORD) & (req_addr[1:0] != 2'b00));
        be_c    = 4'b1111;
        wdata_c = req_wdata;
        case (req_length)
            LEN_BYTE: begin
                be_c    = BE_W'(4'b0001 << req_addr[1:0]);
                wdata_c = {4{req_wdata[7:0]}};
            end
            LEN_HALF: begin
                be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{req_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = req_wdata;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension of the returned bus word.
    always_comb begin
        shifted_c = bus_rdata >> {off_q, 3'b000};
        load_c    = shifted_c;
        case (len_q)
            LEN_BYTE: load_c = sign_q ? {{24{shifted_c[7]}}, shifted_c[7:0]}
                                      : {24'b0, shifted_c[7:0]};
            LEN_HALF: load_c = sign_q ? {{16{shifted_c[15]}}, shifted_c[15:0]}
                                      : {16'b0, shifted_c[15:0]};
            default:  load_c = shifted_c;
        endcase
    end

    // Timeout counter step; a bus event in the same cycle takes precedence.
    always_comb begin
        cnt_inc_c = cnt_q + CNT_W'(1);
        timeout_c = (cnt_inc_c == TIMEOUT_C);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        breq_d        = breq_q;
        bus_valid_d   = bus_valid_q;
        off_d         = off_q;
        len_d         = len_q;
        sign_d        = sign_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        err_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_any_c) begin
                    if (illegal_c) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        breq_d.we    = req_wr_en;
                        breq_d.addr  = {req_addr[31:2], 2'b00};
                        breq_d.wdata = wdata_c;
                        breq_d.be    = be_c;
                        off_d        = req_addr[1:0];
                        len_d        = req_length;
                        sign_d       = req_sign;
                        cnt_d        = '0;
                        bus_valid_d  = 1'b1;
                        state_d      = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_inc_c;
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = breq_q.we ? DONE : WAIT_R;
                end else if (timeout_c) begin
                    bus_valid_d = 1'b0;
                    err_d       = 1'b1;
                    rdata_d     = '0;
                    state_d     = DONE;
                end
            end
            WAIT_R: begin
                cnt_d = cnt_inc_c;
                if (bus_rvalid) begin
                    rdata_d       = load_c;
                    rdata_valid_d = 1'b1;
                    state_d       = DONE;
                end else if (timeout_c) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            breq_q        <= '0;
            bus_valid_q   <= 1'b0;
            off_q         <= 2'b00;
            len_q         <= 2'b00;
            sign_q        <= 1'b0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            breq_q        <= breq_d;
            bus_valid_q   <= bus_valid_d;
            off_q         <= off_d;
            len_q         <= len_d;
            sign_q        <= sign_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            err_q         <= err_d;
        end
    end

    // Stall is combinational so the pipeline is held in the request cycle itself.
    assign stall       = req_any_c & (state_q != DONE);
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign err         = err_q;
    assign bus_valid   = bus_valid_q;
    assign bus_we      = breq_q.we;
    assign bus_addr    = breq_q.addr;
    assign bus_wdata   = breq_q.wdata;
    assign bus_be      = breq_q.be;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge: stimulus pushes expected bus handshakes
// and completions; a negedge monitor pops and compares them as they appear.
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd_en, req_wr_en;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_length;
    logic        req_sign;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid, err;
    logic        bus_valid, bus_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    dmem_bus_bridge #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_rd_en(req_rd_en), .req_wr_en(req_wr_en),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_length(req_length), .req_sign(req_sign),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] kind;     // 0 = bus handshake, 1 = completion (DONE)
        logic [31:0] cyc;
        logic [31:0] addr;
        logic [31:0] be;
        logic [31:0] we;
        logic [31:0] chk_wd;
        logic [31:0] wdata;
        logic [31:0] rv;
        logic [31:0] er;
        logic [31:0] chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   valid_cycles = 0;
    int   c0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp_v, cyc);
        end
    endtask

    task automatic push_hs(input int c, input logic [31:0] a, input logic [3:0] be,
                           input logic we, input logic chk_wd, input logic [31:0] wd);
        exp_t e;
        e = '0;
        e.kind = 32'd0; e.cyc = 32'(c); e.addr = a; e.be = 32'(be);
        e.we = 32'(we); e.chk_wd = 32'(chk_wd); e.wdata = wd;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int c, input logic rv, input logic er,
                             input logic chk_rd, input logic [31:0] rd);
        exp_t e;
        e = '0;
        e.kind = 32'd1; e.cyc = 32'(c); e.rv = 32'(rv); e.er = 32'(er);
        e.chk_rd = 32'(chk_rd); e.rd = rd;
        exp_q.push_back(e);
    endtask

    // Monitor: any handshake or completion must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_valid) valid_cycles++;
            if ((bus_valid && bus_ready) || rdata_valid || err ||
                ((req_rd_en || req_wr_en) && !stall)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got valid=%b ready=%b rvld=%b err=%b stall=%b expected no event (cycle %0d)",
                             bus_valid, bus_ready, rdata_valid, err, stall, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_kind", (bus_valid && bus_ready) ? 32'd0 : 32'd1, mon_e.kind);
                    chk("event_cycle", 32'(cyc), mon_e.cyc);
                    if (mon_e.kind == 32'd0) begin
                        chk("bus_addr", bus_addr, mon_e.addr);
                        chk("bus_be", 32'(bus_be), mon_e.be);
                        chk("bus_we", 32'(bus_we), mon_e.we);
                        if (mon_e.chk_wd != 32'd0) chk("bus_wdata", bus_wdata, mon_e.wdata);
                    end else begin
                        chk("done_rdata_valid", 32'(rdata_valid), mon_e.rv);
                        chk("done_err", 32'(err), mon_e.er);
                        chk("done_bus_valid", 32'(bus_valid), 32'd0);
                        if (mon_e.chk_rd != 32'd0) chk("done_rdata", rdata, mon_e.rd);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: got %0d pending events expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic idle();
        req_rd_en = 1'b0;
        req_wr_en = 1'b0;
        step();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] len,
                            input logic [3:0] ebe, input logic [31:0] ewd);
        c0 = cyc;
        req_rd_en = 1'b0; req_wr_en = 1'b1;
        req_addr = a; req_wdata = wd; req_length = len; req_sign = 1'b0;
        push_hs(c0 + 1, {a[31:2], 2'b00}, ebe, 1'b1, 1'b1, ewd);
        push_done(c0 + 2, 1'b0, 1'b0, 1'b0, 32'h0);
        wait_empty(20);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [1:0] len, input logic sgn,
                           input logic [31:0] word, input logic [3:0] ebe,
                           input logic [31:0] erd, input int d);
        c0 = cyc;
        req_rd_en = 1'b1; req_wr_en = 1'b0;
        req_addr = a; req_wdata = 32'h0; req_length = len; req_sign = sgn;
        push_hs(c0 + 1, {a[31:2], 2'b00}, ebe, 1'b0, 1'b0, 32'h0);
        push_done(c0 + 3 + d, 1'b1, 1'b0, 1'b1, erd);
        step();
        bus_rvalid = 1'b1;           // acceptance-cycle data must be ignored
        bus_rdata  = ~word;
        step();
        bus_rvalid = 1'b0;
        repeat (d) step();
        bus_rvalid = 1'b1;
        bus_rdata  = word;
        step();
        bus_rvalid = 1'b0;
        wait_empty(20);
    endtask

    task automatic do_illegal(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [1:0] len);
        int vc;
        vc = valid_cycles;
        c0 = cyc;
        req_rd_en = rd; req_wr_en = wr;
        req_addr = a; req_wdata = 32'h1234_5678; req_length = len; req_sign = 1'b0;
        push_done(c0 + 1, 1'b0, 1'b1, 1'b0, 32'h0);
        wait_empty(20);
        chk("illegal_no_bus_valid", 32'(valid_cycles), 32'(vc));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_flags"}, {28'h0, rdata_valid, err, bus_valid, bus_we}, 32'h0);
        chk({tag, "_bus_addr"}, bus_addr, 32'h0);
        chk({tag, "_bus_wdata"}, bus_wdata, 32'h0);
        chk({tag, "_bus_be"}, 32'(bus_be), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc;
        rst = 1'b1;
        req_rd_en = 1'b0; req_wr_en = 1'b0;
        req_addr = '0; req_wdata = '0; req_length = 2'b00; req_sign = 1'b0;
        bus_ready = 1'b1; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_vals("reset");

        // Stores and loads with zero-wait bus.
        do_write(32'h0000_1004, 32'hDEAD_BEEF, 2'b10, 4'b1111, 32'hDEAD_BEEF);
        idle();
        do_read(32'h0000_2003, 2'b00, 1'b1, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80, 0);
        idle();
        do_read(32'h0000_2003, 2'b00, 1'b0, 32'h80FF_1234, 4'b1000, 32'h0000_0080, 0);
        idle();
        do_write(32'h0000_0010, 32'h0000_ABCD, 2'b01, 4'b0011, 32'hABCD_ABCD);
        idle();
        do_read(32'h0000_0012, 2'b01, 1'b0, 32'h8001_0000, 4'b1100, 32'h0000_8001, 0);
        idle();
        do_write(32'h0000_0005, 32'h1234_56A7, 2'b00, 4'b0010, 32'hA7A7_A7A7);
        idle();
        do_read(32'h0000_0000, 2'b01, 1'b1, 32'h1234_F00D, 4'b0011, 32'hFFFF_F00D, 1);
        idle();

        // Back-to-back: next request only sampled in the IDLE after DONE.
        do_read(32'h0000_0001, 2'b00, 1'b1, 32'h0000_7F00, 4'b0010, 32'h0000_007F, 0);
        do_write(32'h0000_0300, 32'h0BAD_F00D, 2'b10, 4'b1111, 32'h0BAD_F00D);
        idle();

        // Illegal requests.
        do_illegal(1'b1, 1'b0, 32'h0000_0002, 2'b10);
        idle();
        do_illegal(1'b1, 1'b1, 32'h0000_0000, 2'b10);
        idle();
        do_illegal(1'b0, 1'b1, 32'h0000_0000, 2'b11);
        idle();
        do_illegal(1'b1, 1'b0, 32'h0000_0001, 2'b01);
        idle();

        // Timeout with bus_ready held low.
        bus_ready = 1'b0;
        vc = valid_cycles;
        c0 = cyc;
        req_rd_en = 1'b0; req_wr_en = 1'b1;
        req_addr = 32'h0000_0040; req_wdata = 32'h5555_AAAA; req_length = 2'b10;
        push_done(c0 + 5, 1'b0, 1'b1, 1'b1, 32'h0);
        wait_empty(20);
        chk("timeout_valid_cycles", 32'(valid_cycles - vc), 32'd4);
        bus_ready = 1'b1;
        idle();

        // bus_ready on exactly the timeout cycle wins over the timeout.
        bus_ready = 1'b0;
        c0 = cyc;
        req_rd_en = 1'b0; req_wr_en = 1'b1;
        req_addr = 32'h0000_0044; req_wdata = 32'h1111_2222; req_length = 2'b10;
        push_hs(c0 + 4, 32'h0000_0044, 4'b1111, 1'b1, 1'b1, 32'h1111_2222);
        push_done(c0 + 5, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (4) step();
        bus_ready = 1'b1;
        wait_empty(20);
        idle();

        // Load with two wait cycles leaves nonzero rdata before the reset test.
        do_read(32'h0000_0100, 2'b10, 1'b0, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE, 2);
        idle();

        // Reset asserted in WAIT_R; late bus_rvalid must be ignored.
        c0 = cyc;
        req_rd_en = 1'b1; req_wr_en = 1'b0;
        req_addr = 32'h0000_0080; req_length = 2'b10; req_sign = 1'b0;
        push_hs(c0 + 1, 32'h0000_0080, 4'b1111, 1'b0, 1'b0, 32'h0);
        step();
        step();
        step();
        rst = 1'b1;
        req_rd_en = 1'b0;
        step();
        rst = 1'b0;
        chk_reset_vals("midreset");
        step();
        step();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h55AA_55AA;
        step();
        bus_rvalid = 1'b0;
        repeat (3) step();
        chk("post_reset_rdata", rdata, 32'h0);
        chk("pending_events", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
